// File: rtl/dice_display_if.sv
// Bundle between the dice roller result and the board-level 7-segment pins.
// The display block is the slave; whoever supplies value_in is the master.
interface dice_display_if;
   logic [7:0]  value_in;
   logic        busy;
   logic [11:0] disp_bcd;
   logic [2:0]  digit_en;
   logic [6:0]  seg;

   modport master (
      output value_in,
      input  busy,
      input  disp_bcd,
      input  digit_en,
      input  seg
   );

   modport slave (
      input  value_in,
      output busy,
      output disp_bcd,
      output digit_en,
      output seg
   );
endinterface

// File: rtl/dice_display.sv
// Binary-to-BCD conversion of the rolled number (one double-dabble shift per clock)
// feeding a time-multiplexed 3-digit 7-segment display with blanking and dashes.
module dice_display #(
   parameter int REFRESH_DIV  = 1000,
   parameter bit COMMON_ANODE = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   dice_display_if.slave bus
);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [6:0]  SEG_DASH  = 7'h40;
   localparam logic [6:0]  SEG_BLANK = 7'h00;
   localparam logic [6:0]  SEG_INV   = {7{COMMON_ANODE}};
   localparam logic [2:0]  EN_INV    = {3{COMMON_ANODE}};
   localparam logic [15:0] PRESC_MAX = 16'(REFRESH_DIV - 1);

   state_t      state_q, state_d;
   logic        busy_q, busy_d;
   logic [7:0]  shadow_q, shadow_d;
   logic [7:0]  shift_q, shift_d;
   logic [11:0] scratch_q, scratch_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [11:0] disp_bcd_q, disp_bcd_d;
   logic [15:0] presc_q, presc_d;
   logic [1:0]  digit_idx_q, digit_idx_d;
   logic [2:0]  digit_en_q, digit_en_d;
   logic [6:0]  seg_q, seg_d;

   logic [11:0] adj;
   logic [6:0]  seg_raw;
   logic [2:0]  en_raw;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h3F;
         4'd1:    s = 7'h06;
         4'd2:    s = 7'h5B;
         4'd3:    s = 7'h4F;
         4'd4:    s = 7'h66;
         4'd5:    s = 7'h6D;
         4'd6:    s = 7'h7D;
         4'd7:    s = 7'h07;
         4'd8:    s = 7'h7F;
         4'd9:    s = 7'h6F;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

   // Per-nibble +3 with no carry across nibbles; applied before every shift.
   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_adj
         assign adj[gi*4 +: 4] = (scratch_q[gi*4 +: 4] >= 4'd5) ?
                                 scratch_q[gi*4 +: 4] + 4'd3 : scratch_q[gi*4 +: 4];
      end
   endgenerate

   always_comb begin
      state_d    = state_q;
      busy_d     = busy_q;
      shadow_d   = shadow_q;
      shift_d    = shift_q;
      scratch_d  = scratch_q;
      cnt_d      = cnt_q;
      disp_bcd_d = disp_bcd_q;
      case (state_q)
         IDLE: begin
            if (bus.value_in != shadow_q) begin
               shadow_d  = bus.value_in;
               shift_d   = bus.value_in;
               scratch_d = 12'd0;
               cnt_d     = 4'd0;
               busy_d    = 1'b1;
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            scratch_d = {adj[10:0], shift_q[7]};
            shift_d   = {shift_q[6:0], 1'b0};
            cnt_d     = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
               state_d = DONE;
            end
         end
         DONE: begin
            disp_bcd_d = scratch_q;
            busy_d     = 1'b0;
            state_d    = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Refresh path is free-running and does not care what the converter is doing.
   always_comb begin
      presc_d     = presc_q + 16'd1;
      digit_idx_d = digit_idx_q;
      if (presc_q >= PRESC_MAX) begin
         presc_d     = 16'd0;
         digit_idx_d = (digit_idx_q == 2'd2) ? 2'd0 : digit_idx_q + 2'd1;
      end
   end

   always_comb begin
      seg_raw = SEG_BLANK;
      en_raw  = 3'b001;
      case (digit_idx_q)
         2'd0: begin
            en_raw  = 3'b001;
            seg_raw = seg7(disp_bcd_q[3:0]);
         end
         2'd1: begin
            en_raw  = 3'b010;
            seg_raw = (disp_bcd_q[11:4] == 8'd0) ? SEG_BLANK : seg7(disp_bcd_q[7:4]);
         end
         2'd2: begin
            en_raw  = 3'b100;
            seg_raw = (disp_bcd_q[11:8] == 4'd0) ? SEG_BLANK : seg7(disp_bcd_q[11:8]);
         end
         default: begin
            en_raw  = 3'b001;
            seg_raw = SEG_BLANK;
         end
      endcase
      if (disp_bcd_q == 12'd0) begin
         seg_raw = SEG_DASH;
      end
      digit_en_d = en_raw ^ EN_INV;
      seg_d      = seg_raw ^ SEG_INV;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         busy_q      <= 1'b0;
         shadow_q    <= 8'd0;
         shift_q     <= 8'd0;
         scratch_q   <= 12'd0;
         cnt_q       <= 4'd0;
         disp_bcd_q  <= 12'd0;
         presc_q     <= 16'd0;
         digit_idx_q <= 2'd0;
         digit_en_q  <= 3'b001 ^ EN_INV;
         seg_q       <= SEG_DASH ^ SEG_INV;
      end else begin
         state_q     <= state_d;
         busy_q      <= busy_d;
         shadow_q    <= shadow_d;
         shift_q     <= shift_d;
         scratch_q   <= scratch_d;
         cnt_q       <= cnt_d;
         disp_bcd_q  <= disp_bcd_d;
         presc_q     <= presc_d;
         digit_idx_q <= digit_idx_d;
         digit_en_q  <= digit_en_d;
         seg_q       <= seg_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.disp_bcd = disp_bcd_q;
   assign bus.digit_en = digit_en_q;
   assign bus.seg      = seg_q;

endmodule

// File: tb/tb_dice_display.sv
// Directed bench: one common-cathode and one common-anode instance share stimulus;
// expected BCD results are queued at drive time and popped when busy falls.
module tb_dice_display;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   dice_display_if if0 ();
   dice_display_if if1 ();

   dice_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0)
   );

   dice_display #(.REFRESH_DIV(4), .COMMON_ANODE(1'b1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1)
   );

   int n_assert = 0;
   int n_fail   = 0;
   int k        = 0;
   logic [11:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Edge k after reset release shows the digit selected after edge k-1 (dwell 4).
   function automatic logic [2:0] exp_en(input int kk);
      logic [2:0] e;
      if (kk == 0) begin
         e = 3'b001;
      end else begin
         case (((kk - 1) / 4) % 3)
            0:       e = 3'b001;
            1:       e = 3'b010;
            default: e = 3'b100;
         endcase
      end
      return e;
   endfunction

   task automatic step();
      logic [2:0] e;
      logic [2:0] ei;
      @(posedge clk);
      #1;
      if (rst) k = 0;
      else     k++;
      e  = exp_en(k);
      ei = ~e;
      chk("digit_en_cc", {29'd0, if0.digit_en}, {29'd0, e});
      chk("digit_en_ca", {29'd0, if1.digit_en}, {29'd0, ei});
   endtask

   task automatic set_value(input logic [7:0] v);
      if0.value_in = v;
      if1.value_in = v;
   endtask

   task automatic finish_conv(input int already);
      int n;
      int guard;
      logic [11:0] e;
      n = already;
      guard = 0;
      while (guard < 40) begin
         step();
         guard++;
         if (if0.busy === 1'b0) break;
         n++;
      end
      chk("busy_cycles", n, 9);
      chk("busy_ca", {31'd0, if1.busy}, 32'd0);
      chk("sb_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("disp_bcd_cc", {20'd0, if0.disp_bcd}, {20'd0, e});
         chk("disp_bcd_ca", {20'd0, if1.disp_bcd}, {20'd0, e});
         $display("conversion: disp_bcd=%03h expected=%03h busy_cycles=%0d", if0.disp_bcd, e, n);
      end
   endtask

   task automatic convert(input logic [7:0] v, input logic [11:0] exp_bcd);
      set_value(v);
      exp_q.push_back(exp_bcd);
      step();
      chk("busy_rise", {31'd0, if0.busy}, 32'd1);
      finish_conv(1);
   endtask

   // Collect each digit's pattern over a full refresh sweep, then compare.
   task automatic check_segs(input logic [6:0] h, input logic [6:0] t, input logic [6:0] o);
      logic [6:0] s0 [3];
      logic [6:0] s1 [3];
      logic [6:0] inv;
      for (int i = 0; i < 3; i++) begin
         s0[i] = 7'h11;
         s1[i] = 7'h11;
      end
      for (int i = 0; i < 12; i++) begin
         step();
         case (if0.digit_en)
            3'b001:  s0[0] = if0.seg;
            3'b010:  s0[1] = if0.seg;
            3'b100:  s0[2] = if0.seg;
            default: ;
         endcase
         case (if1.digit_en)
            3'b110:  s1[0] = if1.seg;
            3'b101:  s1[1] = if1.seg;
            3'b011:  s1[2] = if1.seg;
            default: ;
         endcase
      end
      chk("seg_ones_cc", {25'd0, s0[0]}, {25'd0, o});
      chk("seg_tens_cc", {25'd0, s0[1]}, {25'd0, t});
      chk("seg_hund_cc", {25'd0, s0[2]}, {25'd0, h});
      inv = ~o;
      chk("seg_ones_ca", {25'd0, s1[0]}, {25'd0, inv});
      inv = ~t;
      chk("seg_tens_ca", {25'd0, s1[1]}, {25'd0, inv});
      inv = ~h;
      chk("seg_hund_ca", {25'd0, s1[2]}, {25'd0, inv});
      $display("display sweep: hund=%02h tens=%02h ones=%02h", s0[2], s0[1], s0[0]);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},   {31'd0, if0.busy},     32'd0);
      chk({tag, "_disp"},   {20'd0, if0.disp_bcd}, 32'd0);
      chk({tag, "_en_cc"},  {29'd0, if0.digit_en}, 32'h1);
      chk({tag, "_seg_cc"}, {25'd0, if0.seg},      32'h40);
      chk({tag, "_en_ca"},  {29'd0, if1.digit_en}, 32'h6);
      chk({tag, "_seg_ca"}, {25'd0, if1.seg},      32'h3F);
   endtask

   initial begin
      rst = 1'b1;
      set_value(8'd0);
      #1;
      check_reset_outputs("reset_async");
      step();
      step();
      rst = 1'b0;

      // Idle with no roll: dashes everywhere, busy never rises.
      for (int i = 0; i < 12; i++) begin
         step();
         chk("idle_busy", {31'd0, if0.busy}, 32'd0);
         chk("idle_disp", {20'd0, if0.disp_bcd}, 32'd0);
      end
      check_segs(7'h40, 7'h40, 7'h40);

      convert(8'd17, 12'h017);
      check_segs(7'h00, 7'h06, 7'h07);

      convert(8'd20, 12'h020);
      check_segs(7'h00, 7'h5B, 7'h3F);

      convert(8'd4, 12'h004);
      check_segs(7'h00, 7'h00, 7'h66);

      convert(8'd255, 12'h255);
      check_segs(7'h5B, 7'h6D, 7'h6D);

      // 6 -> 8 -> 20 on consecutive cycles: 8 must be skipped.
      set_value(8'd6);
      exp_q.push_back(12'h006);
      exp_q.push_back(12'h020);
      step();
      chk("busy_rise_6", {31'd0, if0.busy}, 32'd1);
      set_value(8'd8);
      step();
      set_value(8'd20);
      finish_conv(2);
      step();
      chk("busy_rise_20", {31'd0, if0.busy}, 32'd1);
      finish_conv(1);
      check_segs(7'h00, 7'h5B, 7'h3F);

      // Asynchronous reset between E4 and E5, then a fresh conversion of 13.
      set_value(8'd13);
      step();
      chk("busy_rise_13", {31'd0, if0.busy}, 32'd1);
      for (int i = 0; i < 4; i++) step();
      #2;
      rst = 1'b1;
      k = 0;
      #1;
      check_reset_outputs("reset_mid");
      #1;
      rst = 1'b0;
      exp_q.push_back(12'h013);
      step();
      chk("busy_rise_after_rst", {31'd0, if0.busy}, 32'd1);
      finish_conv(1);
      check_segs(7'h00, 7'h06, 7'h4F);

      chk("sb_drained", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/dice_display.md
Name: dice_display

Overview:
- Downstream consumer of the dice roller's 8-bit `rolled_number` result.
- Converts the value to three BCD digits using an iterative double-dabble FSM (one shift per clock).
- Drives a time-multiplexed 3-digit 7-segment display, with leading-zero blanking and a "no roll yet" dash pattern for value 0.
- Sits between the roller and the board-level display pins.

Parameters:
- REFRESH_DIV, 1000: clock cycles each digit stays selected; legal range 2..65535.
- COMMON_ANODE, 0: 1 inverts `seg` and `digit_en` at the output registers (active-low pins).

Ports:
- clk  input  1  system clock
- rst  input  1  reset; asynchronous assert, active-high
- value_in  input  8  result from the roller; 0 = no roll yet, otherwise 1..255
- busy  output  1  high while a conversion is in progress
- disp_bcd  output  12  displayed value as BCD: [11:8] hundreds, [7:4] tens, [3:0] ones
- digit_en  output  3  one-hot digit select: [0] ones, [1] tens, [2] hundreds
- seg  output  7  segment drive, bit order {g,f,e,d,c,b,a}

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (`rst`).
- Reset values:
  - state = IDLE, busy = 0, shadow = 0, disp_bcd = 0.
  - Refresh prescaler = 0, digit_idx = 0.
  - digit_en = 3'b001, seg = 7'h40 (dash).
  - Both outputs are inverted if COMMON_ANODE = 1.
- Reset mid-conversion: the conversion is aborted, and all of the above apply immediately.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - If value_in != shadow on a clock edge (call it E0):
    - shadow <= value_in; shift register <= value_in.
    - BCD scratch <= 0; bit counter <= 0; busy <= 1; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT (edges E1..E8, one per edge):
  - Each scratch nibble >= 5 gets +3 first (combinational adjust).
  - Then {scratch, shiftreg} shifts left by 1; counter increments.
  - After the 8th shift, go to DONE.
- DONE (edge E9): disp_bcd <= scratch; busy <= 0; go to IDLE.
- Latency: a change sampled at E0 appears on disp_bcd at E9. busy is high for exactly 9 cycles.
- value_in changes while busy are ignored. On return to IDLE, the next compare against shadow picks up the latest value, so the final value always wins. Intermediate values may never be displayed.
- Width rules:
  - Scratch is 12 bits. No nibble exceeds 9 after conversion; the maximum is 255 -> 2,5,5.
  - The +3 adjust is per-nibble, 4-bit, with no carry between nibbles.
- Refresh:
  - Prescaler counts 0..REFRESH_DIV-1 every clock, wrapping to 0.
  - On the wrap cycle, digit_idx advances 0 -> 1 -> 2 -> 0.
  - The refresh path runs continuously and independently of the FSM.
- Output registers:
  - Each clock, digit_en <= onehot(digit_idx) and seg <= decode(digit_idx, disp_bcd).
  - Outputs therefore lag digit_idx by one cycle. Both change on the same edge, so they never disagree.
- Digit decode (gfedcba):
  - 0..9 = 3F, 06, 5B, 4F, 66, 6D, 7D, 07, 7F, 6F.
  - blank = 00; dash = 40.
- Blanking and dashes:
  - If disp_bcd == 0, all three digits show dash.
  - Otherwise hundreds is blank when hundreds == 0, and tens is blank when hundreds == 0 and tens == 0.
  - Ones is never blank.
  - digit_en still asserts for blanked digits.
- Nibble values 10..15 cannot occur; decode them to blank.
- COMMON_ANODE = 1: seg and digit_en are bitwise inverted at the register input, including their reset values.

Test Plan:
- Reset, then hold value_in = 0 (REFRESH_DIV = 4) -> busy never rises; disp_bcd = 000; seg = 40 on every digit; digit_en cycles 001, 010, 100 with a 4-cycle dwell each.
- value_in 0 -> 17 at edge E0 -> busy high E0..E8, low at E9; disp_bcd = 0x017 at E9; hundreds digit seg = 00, tens = 06, ones = 07.
- value_in = 20, then 4 -> disp_bcd = 0x020 (ones seg 3F, tens 5B, hundreds blank), then 0x004 (tens and hundreds blank, ones 66).
- value_in = 255 -> disp_bcd = 0x255; all three digits lit (5B, 6D, 6D).
- value_in steps 6 -> 8 -> 20 on consecutive cycles starting at E0 -> first conversion yields 0x006 at E9; a second conversion starts at E10 and yields 0x020 at E19; 8 is never displayed.
- rst pulsed asynchronously mid-conversion (between edges E4 and E5), released, value_in held at 13 -> outputs go to reset values immediately without waiting for a clock; a fresh conversion starts on the first edge after release and yields disp_bcd = 0x013 nine cycles later. Repeat with COMMON_ANODE = 1 -> seg and digit_en are the bitwise inverses of the above.
